// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter for the UART slave chip-select bus.
// Holds cs for one complete slave access, with a dead-slave timeout and a recovery gap.
module uart_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_bytesel,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_bytesel,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        cs,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wr_val,
    output logic [3:0]  bus_bytesel,
    input  logic        bus_ack,
    input  logic [31:0] bus_data,
    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOVER
    } state_t;

    // Completion is decided on the cycle whose incremented count would equal TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cs_q, cs_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wr_val_q, wr_val_d;
    logic [3:0]  bsel_q, bsel_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        tout_q, tout_d;

    logic        ack_ok;
    logic        expired;
    logic        pick_m1;
    logic [31:0] done_data;

    // The first ACCESS cycle's bus_ack is the slave's registered view of the previous cs.
    assign ack_ok    = (state_q == ACCESS) && bus_ack && (cnt_q != 8'd0);
    assign expired   = (state_q == ACCESS) && !ack_ok && (cnt_q == CNT_LAST);
    assign pick_m1   = (m0_req && m1_req) ? !last_grant_q : m1_req;
    assign done_data = ack_ok ? bus_data : 32'hFFFF_FFFF;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        cs_d         = cs_q;
        addr_d       = addr_q;
        wr_val_d     = wr_val_q;
        bsel_d       = bsel_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = 32'd0;
        m1_rdata_d   = 32'd0;
        tout_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d      = pick_m1;
                    last_grant_d = pick_m1;
                    addr_d       = pick_m1 ? m1_addr    : m0_addr;
                    wr_val_d     = pick_m1 ? m1_wdata   : m0_wdata;
                    bsel_d       = pick_m1 ? m1_bytesel : m0_bytesel;
                    cs_d         = 1'b1;
                    cnt_d        = 8'd0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (ack_ok || expired) begin
                    m0_ack_d   = !grant_q;
                    m1_ack_d   = grant_q;
                    m0_rdata_d = grant_q ? 32'd0 : done_data;
                    m1_rdata_d = grant_q ? done_data : 32'd0;
                    tout_d     = expired;
                    cs_d       = 1'b0;
                    state_d    = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            cs_q         <= 1'b0;
            addr_q       <= 32'd0;
            wr_val_q     <= 32'd0;
            bsel_q       <= 4'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= 32'd0;
            m1_rdata_q   <= 32'd0;
            tout_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cs_q         <= cs_d;
            addr_q       <= addr_d;
            wr_val_q     <= wr_val_d;
            bsel_q       <= bsel_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            tout_q       <= tout_d;
        end
    end

    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign cs          = cs_q;
    assign bus_addr    = addr_q;
    assign bus_wr_val  = wr_val_q;
    assign bus_bytesel = bsel_q;
    assign grant       = grant_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter with a registered-ack UART slave model.
// Latencies are counted in rising edges after the granting edge.
module tb_uart_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_bytesel = '0, m1_bytesel = '0;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        cs, bus_ack, grant, busy, timeout_err;
    logic [31:0] bus_addr, bus_wr_val, bus_data;
    logic [3:0]  bus_bytesel;
    logic        slave_dead = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_bus_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_bytesel(m0_bytesel),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_bytesel(m1_bytesel),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .cs(cs), .bus_addr(bus_addr), .bus_wr_val(bus_wr_val), .bus_bytesel(bus_bytesel),
        .bus_ack(bus_ack), .bus_data(bus_data),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slave_lookup(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0;
            32'h4:   return 32'h2;
            default: return 32'hA500_0000 | a;
        endcase
    endfunction

    // Slave registers its ack and data from cs, so ack lingers one cycle after cs drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_ack  <= 1'b0;
            bus_data <= 32'd0;
        end else begin
            bus_ack  <= cs && !slave_dead;
            bus_data <= (cs && !slave_dead) ? slave_lookup(bus_addr) : 32'd0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic do_txn(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] bsel, input logic [31:0] exp_rd,
                          input int exp_lat, input logic exp_to, input string tag);
        int          lat;
        int          cs_cnt;
        logic        got;
        logic        other_seen;
        logic [31:0] rd;
        logic        to;
        lat = -1; cs_cnt = 0; got = 1'b0; other_seen = 1'b0; rd = '0; to = 1'b0;
        if (m == 0) begin
            m0_req = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_bytesel = bsel;
        end else begin
            m1_req = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_bytesel = bsel;
        end
        for (int i = 1; i <= 40 && !got; i++) begin
            tick();
            if (i == 1) begin
                check({tag, "_grant"}, 32'(grant), 32'(m));
                check({tag, "_bus_addr"}, bus_addr, addr);
                check({tag, "_bus_wr_val"}, bus_wr_val, wdata);
                check({tag, "_bus_bytesel"}, 32'(bus_bytesel), 32'(bsel));
                check({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (cs) cs_cnt++;
            if ((m == 0) ? m1_ack : m0_ack) other_seen = 1'b1;
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1'b1;
                lat = i - 1;
                rd  = (m == 0) ? m0_rdata : m1_rdata;
                to  = timeout_err;
            end
        end
        check({tag, "_acked"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_timeout_err"}, 32'(to), 32'(exp_to));
        check({tag, "_cs_cycles"}, 32'(cs_cnt), 32'(exp_lat));
        check({tag, "_other_ack"}, 32'(other_seen), 32'd0);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, 32'(m0_ack | m1_ack), 32'd0);
        check({tag, "_rdata_clr"}, m0_rdata | m1_rdata, 32'd0);
        check({tag, "_tout_pulse"}, 32'(timeout_err), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          prev;
        logic        both_seen;
        logic        got;
        logic        again;
        int          lat;
        logic [31:0] rd;

        // Reset values
        tick();
        check("rst_cs", 32'(cs), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wr_val", bus_wr_val, 32'd0);
        check("rst_bus_bytesel", 32'(bus_bytesel), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tout", 32'(timeout_err), 32'd0);
        resetn = 1'b1;
        tick();

        // Single read and a write
        do_txn(0, 32'h4, 32'h0, 4'b1111, 32'h2, 2, 1'b0, "read_m0");
        do_txn(1, 32'h0, 32'h41, 4'b0001, 32'h0, 2, 1'b0, "write_m1");
        check("hold_bus_wr_val", bus_wr_val, 32'h41);

        // Stale ack: m1 requests the moment m0 is acked
        m0_req = 1'b1; m0_addr = 32'h4; m0_bytesel = 4'b1111;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = m0_ack;
        end
        check("stale_m0_acked", 32'(got), 32'd1);
        m0_req = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h20; m1_bytesel = 4'b1111;
        got = 1'b0; again = 1'b0; lat = -1; rd = '0;
        for (int k = 1; k <= 8 && !got; k++) begin
            tick();
            if (m0_ack) again = 1'b1;
            if (m1_ack) begin
                got = 1'b1; lat = k; rd = m1_rdata;
            end
        end
        m1_req = 1'b0;
        check("stale_m1_acked", 32'(got), 32'd1);
        check("stale_m1_gap", 32'(lat), 32'd4);
        check("stale_m1_rdata", rd, 32'hA500_0020);
        check("stale_m0_reack", 32'(again), 32'd0);
        tick();
        check("stale_idle", 32'(busy), 32'd0);

        // Dead slave forces a timeout
        slave_dead = 1'b1;
        do_txn(0, 32'hC, 32'h0, 4'b1111, 32'hFFFF_FFFF, 15, 1'b1, "timeout_m0");
        slave_dead = 1'b0;

        // Reset one cycle into ACCESS
        m0_req = 1'b1; m0_addr = 32'h4; m0_bytesel = 4'b1111;
        tick();
        check("rmid_cs_up", 32'(cs), 32'd1);
        tick();
        resetn = 1'b0;
        #1;
        check("rmid_cs", 32'(cs), 32'd0);
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_bus_addr", bus_addr, 32'd0);
        m0_req = 1'b0;
        tick();
        resetn = 1'b1;
        again = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m0_ack || m1_ack) again = 1'b1;
        end
        check("rmid_no_ack", 32'(again), 32'd0);
        do_txn(0, 32'h4, 32'h0, 4'b1111, 32'h2, 2, 1'b0, "rmid_retry");

        // Contention from reset: strict alternation, 4 cycles between acks
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h4; m0_bytesel = 4'b1111;
        m1_req = 1'b1; m1_addr = 32'h8; m1_bytesel = 4'b1111;
        n = 0; prev = 0; both_seen = 1'b0;
        for (int c = 1; c <= 60 && n < 6; c++) begin
            tick();
            if (m0_ack && m1_ack) both_seen = 1'b1;
            if (m0_ack || m1_ack) begin
                check($sformatf("rr_order%0d", n), 32'(m1_ack), 32'(n % 2));
                check($sformatf("rr_rdata%0d", n), m1_ack ? m1_rdata : m0_rdata,
                      (n % 2 == 1) ? 32'hA500_0008 : 32'h2);
                if (n > 0) check($sformatf("rr_gap%0d", n), 32'(c - prev), 32'd4);
                prev = c;
                n++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check("rr_count", 32'(n), 32'd6);
        check("rr_dual_ack", 32'(both_seen), 32'd0);
        tick();
        tick();
        check("rr_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
